alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares one 8-bit ALU (FORWARD/ADD/AND/OR, 3-bit select, ZERO flag) between two requesters, e.g. the main datapath and a debug/branch-compare unit.
- Arbitrates round-robin and drives the ALU operands and select from registers.
- Waits a programmable number of settle cycles, then captures RESULT/ZERO and returns them with a one-cycle ACK.
- Rejects unsupported opcodes without issuing them to the ALU.

Parameters:
SETTLE_CYCLES, 2, clock cycles ALU inputs are held stable before RESULT/ZERO are sampled; legal range 1..15.

Ports:
CLK  input  1  clock; all state changes on rising edge
RESET  input  1  synchronous, active-low reset
REQ0  input  1  requester 0 request; held high with stable OP0/A0/B0 until ACK0
OP0  input  3  requester 0 opcode (000 FWD, 001 ADD, 010 AND, 011 OR)
A0  input  8  requester 0 operand DATA1
B0  input  8  requester 0 operand DATA2
REQ1  input  1  requester 1 request, same rules as REQ0
OP1  input  3  requester 1 opcode
A1  input  8  requester 1 operand DATA1
B1  input  8  requester 1 operand DATA2
ACK0  output  1  one-cycle pulse: requester 0 operation complete
ACK1  output  1  one-cycle pulse: requester 1 operation complete
RES  output  8  captured result; valid only while ACK0 or ACK1 is high
RES_ZERO  output  1  captured ALU ZERO; valid with ACK
ERR  output  1  opcode rejected; valid with ACK
BUSY  output  1  high in any state other than IDLE
GNT_ID  output  1  id of the current or most recent grantee
ALU_DATA1  output  8  to ALU DATA1
ALU_DATA2  output  8  to ALU DATA2
ALU_SELECT  output  3  to ALU SELECT
ALU_RESULT  input  8  from ALU RESULT
ALU_ZERO  input  1  from ALU ZERO

Behaviour:
- Reset is sampled only at the CLK edge while RESET=0. It is honoured from any state and the in-flight operation is discarded.
- Reset values: state IDLE; ALU_DATA1=0, ALU_DATA2=0, ALU_SELECT=000; ACK0=ACK1=0; RES=0; RES_ZERO=0; ERR=0; BUSY=0; GNT_ID=0; last_served=1, so requester 0 wins the first tie; settle counter=0.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - No REQ: stay in IDLE.
  - Exactly one REQ high: grant it.
  - Both REQ high: grant the requester that is not last_served.
  - On grant: GNT_ID and last_served take the grantee id.
  - Grantee OP[2]=0: register A/B/OP into ALU_DATA1/ALU_DATA2/ALU_SELECT, load counter with SETTLE_CYCLES, go to WAIT.
  - Grantee OP[2]=1: ALU_* unchanged; set RES=0, RES_ZERO=0, ERR=1; assert the grantee's ACK; go to DONE.
- WAIT:
  - ALU_* held constant; counter decrements each cycle.
  - At the edge where counter==1: RES=ALU_RESULT, RES_ZERO=ALU_ZERO, ERR=0; assert the grantee's ACK; go to DONE.
- DONE:
  - ACK is high for exactly this one cycle.
  - Next edge: ACK=0, go to IDLE.
  - REQ values sampled in DONE are ignored.
  - RES/RES_ZERO/ERR hold until the next capture.
- Latency: REQ sampled at edge k gives ALU_* valid after k and ACK high from edge k+1+SETTLE_CYCLES for one cycle. A rejected opcode gives ACK high from edge k+1.
- Throughput: at most one operation per SETTLE_CYCLES+2 cycles. There is always one IDLE cycle between operations.
- Requester rule: deassert REQ on the edge after seeing ACK. A REQ still high in IDLE is treated as a new request.
- Fairness: with both REQ continuously high, grants strictly alternate.
- ACK0 and ACK1 are never high in the same cycle.
- RES_ZERO is ALU ZERO as sampled. That flag reflects DATA1+DATA2==0 whatever the select, and is passed through unmodified.
- Operands or OP changing while a request is granted but not yet ACKed have no effect; the registered copy is used.
- A REQ that drops before its grant is simply not served.

Test Plan:
- Reset: hold RESET=0 for 3 cycles with REQ0=1 -> all outputs at reset values, no ACK, BUSY=0.
- Single ADD: REQ0, OP0=001, A0=0x8F, B0=0x09, SETTLE_CYCLES=2 -> ALU_SELECT=001 one edge later; ACK0 pulse 3 edges after the request edge; RES=0x98, RES_ZERO=0, ERR=0.
- Zero flag: REQ1, OP1=001, A1=0xFF, B1=0x01 -> ACK1 with RES=0x00, RES_ZERO=1.
- Contention: REQ0 and REQ1 both high continuously; requester 0 does AND 0x0F,0x59, requester 1 does OR 0x0F,0x79 -> ACK0 (RES=0x09), then ACK1 (RES=0x7F), then ACK0 again; never both ACKs together.
- Illegal opcode: REQ0, OP0=100 -> ACK0 one edge after grant with ERR=1, RES=0; ALU_* unchanged.
- Reset mid-WAIT: assert RESET=0 one cycle after grant -> no ACK issued, reset values restored; the next tie after reset is granted to requester 0.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one 8-bit ALU between two requesters.
// Operands are registered, held for SETTLE_CYCLES, then the result is captured.
module alu_share_arbiter #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       REQ0,
    input  logic [2:0] OP0,
    input  logic [7:0] A0,
    input  logic [7:0] B0,
    input  logic       REQ1,
    input  logic [2:0] OP1,
    input  logic [7:0] A1,
    input  logic [7:0] B1,
    output logic       ACK0,
    output logic       ACK1,
    output logic [7:0] RES,
    output logic       RES_ZERO,
    output logic       ERR,
    output logic       BUSY,
    output logic       GNT_ID,
    output logic [7:0] ALU_DATA1,
    output logic [7:0] ALU_DATA2,
    output logic [2:0] ALU_SELECT,
    input  logic [7:0] ALU_RESULT,
    input  logic       ALU_ZERO
);

    localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t     state_q, state_d;
    logic [7:0] data1_q, data1_d;
    logic [7:0] data2_q, data2_d;
    logic [2:0] sel_q, sel_d;
    logic [7:0] res_q, res_d;
    logic [3:0] cnt_q, cnt_d;
    logic       ack0_q, ack0_d;
    logic       ack1_q, ack1_d;
    logic       zero_q, zero_d;
    logic       err_q, err_d;
    logic       gnt_q, gnt_d;
    logic       last_q, last_d;

    logic       gnt_w;
    logic [2:0] op_w;
    logic [7:0] a_w;
    logic [7:0] b_w;

    // On a tie the requester that was not served last wins.
    always_comb begin
        gnt_w = (REQ0 && REQ1) ? ~last_q : REQ1;
        op_w  = gnt_w ? OP1 : OP0;
        a_w   = gnt_w ? A1 : A0;
        b_w   = gnt_w ? B1 : B0;
    end

    always_comb begin
        state_d = state_q;
        data1_d = data1_q;
        data2_d = data2_q;
        sel_d   = sel_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        ack0_d  = ack0_q;
        ack1_d  = ack1_q;
        zero_d  = zero_q;
        err_d   = err_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        unique case (state_q)
            S_IDLE: begin
                if (REQ0 || REQ1) begin
                    gnt_d  = gnt_w;
                    last_d = gnt_w;
                    if (!op_w[2]) begin
                        data1_d = a_w;
                        data2_d = b_w;
                        sel_d   = op_w;
                        cnt_d   = SETTLE;
                        state_d = S_WAIT;
                    end else begin
                        res_d   = 8'h00;
                        zero_d  = 1'b0;
                        err_d   = 1'b1;
                        ack0_d  = ~gnt_w;
                        ack1_d  = gnt_w;
                        state_d = S_DONE;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    res_d   = ALU_RESULT;
                    zero_d  = ALU_ZERO;
                    err_d   = 1'b0;
                    ack0_d  = ~gnt_q;
                    ack1_d  = gnt_q;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                ack0_d  = 1'b0;
                ack1_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q <= S_IDLE;
            data1_q <= 8'h00;
            data2_q <= 8'h00;
            sel_q   <= 3'b000;
            res_q   <= 8'h00;
            cnt_q   <= 4'd0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            data1_q <= data1_d;
            data2_q <= data2_d;
            sel_q   <= sel_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
        end
    end

    assign ACK0       = ack0_q;
    assign ACK1       = ack1_q;
    assign RES        = res_q;
    assign RES_ZERO   = zero_q;
    assign ERR        = err_q;
    assign BUSY       = (state_q != S_IDLE);
    assign GNT_ID     = gnt_q;
    assign ALU_DATA1  = data1_q;
    assign ALU_DATA2  = data2_q;
    assign ALU_SELECT = sel_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed cases plus random traffic
// compared every cycle against a transaction-level schedule model.
module tb_alu_share_arbiter;

    localparam int S = 2;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       req[2];
    logic [2:0] op[2];
    logic [7:0] a[2];
    logic [7:0] b[2];
    logic       ACK0, ACK1, RES_ZERO, ERR, BUSY, GNT_ID;
    logic [7:0] RES, ALU_DATA1, ALU_DATA2, alu_r;
    logic [2:0] ALU_SELECT;
    logic [7:0] alu_sum;
    logic       alu_z;

    int n_chk = 0;
    int n_pass = 0;

    alu_share_arbiter #(.SETTLE_CYCLES(S)) dut (
        .CLK(CLK), .RESET(RESET),
        .REQ0(req[0]), .OP0(op[0]), .A0(a[0]), .B0(b[0]),
        .REQ1(req[1]), .OP1(op[1]), .A1(a[1]), .B1(b[1]),
        .ACK0(ACK0), .ACK1(ACK1), .RES(RES), .RES_ZERO(RES_ZERO),
        .ERR(ERR), .BUSY(BUSY), .GNT_ID(GNT_ID),
        .ALU_DATA1(ALU_DATA1), .ALU_DATA2(ALU_DATA2),
        .ALU_SELECT(ALU_SELECT),
        .ALU_RESULT(alu_r), .ALU_ZERO(alu_z)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] fx(logic [2:0] o, logic [7:0] x, logic [7:0] y);
        case (o)
            3'd0: return x;
            3'd1: return x + y;
            3'd2: return x & y;
            3'd3: return x | y;
            default: return 8'h00;
        endcase
    endfunction

    // ALU stand-in: ZERO flags the sum whatever the select
    assign alu_r   = fx(ALU_SELECT, ALU_DATA1, ALU_DATA2);
    assign alu_sum = ALU_DATA1 + ALU_DATA2;
    assign alu_z   = (alu_sum == 8'h00);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Model: an op occupies [grant, free); ACK rises at ack_at and falls at free.
    int         cyc = 0;
    bit         m_valid = 0;
    bit         m_busy, m_ack0, m_ack1, m_zero, m_err, m_gnt, m_last;
    bit         p_zero;
    logic [7:0] m_d1, m_d2, m_res, p_res;
    logic [2:0] m_sel;
    int         m_ack_at, m_free_at;

    always @(posedge CLK) begin
        int g;
        cyc++;
        if (!RESET) begin
            m_valid = 1; m_busy = 0; m_ack0 = 0; m_ack1 = 0;
            m_d1 = 0; m_d2 = 0; m_sel = 0; m_res = 0;
            m_zero = 0; m_err = 0; m_gnt = 0; m_last = 1;
        end else if (m_busy) begin
            if (cyc == m_free_at) begin
                m_busy = 0; m_ack0 = 0; m_ack1 = 0;
            end else if (cyc == m_ack_at) begin
                m_res = p_res; m_zero = p_zero; m_err = 0;
                if (m_gnt) m_ack1 = 1; else m_ack0 = 1;
            end
        end else if (req[0] || req[1]) begin
            g = (req[0] && req[1]) ? int'(!m_last) : int'(req[1]);
            m_gnt = g[0]; m_last = g[0]; m_busy = 1;
            if (op[g][2]) begin
                m_res = 0; m_zero = 0; m_err = 1;
                if (g == 1) m_ack1 = 1; else m_ack0 = 1;
                m_free_at = cyc + 1;
            end else begin
                m_d1 = a[g]; m_d2 = b[g]; m_sel = op[g];
                p_res = fx(op[g], a[g], b[g]);
                p_zero = (8'(a[g] + b[g]) == 8'h00);
                m_ack_at = cyc + S;
                m_free_at = cyc + S + 1;
            end
        end
    end

    always @(negedge CLK) begin
        if (m_valid) begin
            chk("ack0", 32'(ACK0), 32'(m_ack0));
            chk("ack1", 32'(ACK1), 32'(m_ack1));
            chk("ack_excl", 32'(ACK0 & ACK1), 32'(0));
            chk("busy", 32'(BUSY), 32'(m_busy));
            chk("gnt_id", 32'(GNT_ID), 32'(m_gnt));
            chk("alu_ops", {8'h0, ALU_DATA1, ALU_DATA2, 5'h0, ALU_SELECT},
                {8'h0, m_d1, m_d2, 5'h0, m_sel});
            chk("res", {22'h0, ERR, RES_ZERO, RES}, {22'h0, m_err, m_zero, m_res});
        end
    end

    task automatic raise(input int r, input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        req[r] = 1'b1; op[r] = o; a[r] = x; b[r] = y;
    endtask

    task automatic wait_ack(input int r, output int lat, output logic [2:0] sel1);
        lat = 0;
        sel1 = 3'b111;
        for (int i = 1; i <= 30; i++) begin
            @(negedge CLK);
            if (i == 1) sel1 = ALU_SELECT;
            if ((r == 0) ? ACK0 : ACK1) begin
                lat = i;
                return;
            end
        end
        chk("ack_timeout", 32'(0), 32'(1));
    endtask

    initial begin
        int lat;
        logic [2:0] s1;
        int ids[3];
        logic [7:0] rs[3];
        int nack;
        logic ak;
        for (int r = 0; r < 2; r++) begin
            req[r] = 0; op[r] = 0; a[r] = 0; b[r] = 0;
        end
        // reset held with a pending request
        raise(0, 3'd1, 8'h11, 8'h22);
        repeat (3) begin
            @(negedge CLK);
            chk("rst_ack", 32'({ACK0, ACK1}), 32'(0));
            chk("rst_busy", 32'(BUSY), 32'(0));
            chk("rst_sel", 32'(ALU_SELECT), 32'(0));
            chk("rst_res", 32'({ERR, RES_ZERO, RES}), 32'(0));
        end
        req[0] = 0;
        RESET = 1;
        @(negedge CLK);

        raise(0, 3'd1, 8'h8F, 8'h09);
        wait_ack(0, lat, s1);
        req[0] = 0;
        chk("add_sel", 32'(s1), 32'(1));
        chk("add_lat", 32'(lat), 32'(3));
        chk("add_res", 32'({ERR, RES_ZERO, RES}), 32'(10'h098));
        @(negedge CLK);

        raise(1, 3'd1, 8'hFF, 8'h01);
        wait_ack(1, lat, s1);
        req[1] = 0;
        chk("zero_lat", 32'(lat), 32'(3));
        chk("zero_res", 32'({ERR, RES_ZERO, RES}), 32'(10'h100));
        @(negedge CLK);

        raise(0, 3'd2, 8'h0F, 8'h59);
        raise(1, 3'd3, 8'h0F, 8'h79);
        nack = 0;
        for (int i = 0; i < 40 && nack < 3; i++) begin
            @(negedge CLK);
            if (ACK0 || ACK1) begin
                ids[nack] = ACK1 ? 1 : 0;
                rs[nack] = RES;
                nack++;
            end
        end
        req[0] = 0; req[1] = 0;
        chk("cont_count", 32'(nack), 32'(3));
        chk("cont_ids", 32'({ids[0][3:0], ids[1][3:0], ids[2][3:0]}), 32'(12'h010));
        chk("cont_res", 32'({rs[0], rs[1], rs[2]}), 32'(24'h097F09));
        @(negedge CLK);

        raise(0, 3'd4, 8'hAA, 8'h55);
        wait_ack(0, lat, s1);
        req[0] = 0;
        chk("ill_lat", 32'(lat), 32'(1));
        chk("ill_res", 32'({ERR, RES_ZERO, RES}), 32'(10'h200));
        chk("ill_alu", 32'({ALU_SELECT, ALU_DATA1, ALU_DATA2}), 32'({3'd2, 16'h0F59}));
        @(negedge CLK);

        raise(0, 3'd1, 8'h01, 8'h02);
        @(negedge CLK);
        chk("mid_busy", 32'(BUSY), 32'(1));
        RESET = 0;
        req[0] = 0;
        @(negedge CLK);
        chk("mid_rst", 32'({ACK0, ACK1, BUSY, GNT_ID, ALU_DATA1}), 32'(0));
        RESET = 1;
        raise(0, 3'd0, 8'h33, 8'h00);
        raise(1, 3'd0, 8'h44, 8'h00);
        nack = 0;
        for (int i = 0; i < 20 && nack == 0; i++) begin
            @(negedge CLK);
            if (ACK0 || ACK1) begin
                ids[0] = ACK1 ? 1 : 0;
                rs[0] = RES;
                nack = 1;
            end
        end
        req[0] = 0; req[1] = 0;
        chk("post_rst_tie", 32'({nack[3:0], ids[0][3:0], rs[0]}), 32'(16'h1033));
        repeat (2) @(negedge CLK);

        for (int c = 0; c < 3000; c++) begin
            @(negedge CLK);
            if (!RESET) RESET = 1;
            else if ($urandom_range(0, 599) == 0) RESET = 0;
            for (int r = 0; r < 2; r++) begin
                ak = (r == 0) ? ACK0 : ACK1;
                if (req[r] && ak) begin
                    req[r] = 0;
                end else if (!req[r] && $urandom_range(0, 2) == 0) begin
                    req[r] = 1;
                    if ($urandom_range(0, 7) == 0) op[r] = 3'($urandom_range(4, 7));
                    else op[r] = 3'($urandom_range(0, 3));
                    a[r] = 8'($urandom);
                    b[r] = ($urandom_range(0, 5) == 0) ? 8'(-a[r]) : 8'($urandom);
                end else if (req[r] && $urandom_range(0, 3) == 0) begin
                    a[r] = 8'($urandom);
                    b[r] = 8'($urandom);
                end
            end
        end
        RESET = 1;
        req[0] = 0; req[1] = 0;
        repeat (S + 4) @(negedge CLK);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
